// File: rtl/bram_pkg.sv
// Shared constants for the dual-port BRAM: read-during-write mode tags,
// the clear-FSM state encoding and the byte-lane count helper.
package bram_pkg;

  // Mode tags are padded to a common width so they compare exactly against the RD_MODE parameter.
  localparam int RD_MODE_W = 88;
  localparam logic [RD_MODE_W-1:0] RD_READ_FIRST  = {8'h00, "READ_FIRST"};
  localparam logic [RD_MODE_W-1:0] RD_WRITE_FIRST = "WRITE_FIRST";
  localparam logic [RD_MODE_W-1:0] RD_NO_CHANGE   = {16'h0000, "NO_CHANGE"};

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic int calc_nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/bram_init_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// releases the array to the ports.
//
// state    | meaning
// ST_CLEAR | zeroing mem[cnt]; port accesses ignored
// ST_RUN   | normal operation
module bram_init_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == {ADDR_W{1'b1}}) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign init_busy = (state == ST_CLEAR);
  // A reset cycle must not touch memory, even with the FSM parked in CLEAR.
  assign clr_we    = (state == ST_CLEAR) && !rst;
  assign clr_addr  = cnt;

endmodule

// File: rtl/bram_sync_dp.sv
// True dual-port synchronous BRAM with byte enables, selectable same-port
// read-during-write mode and post-reset clear. Optional BRAM_OUT_REG_EN adds an output register stage.
module bram_sync_dp
  import bram_pkg::*;
#(
  parameter int                     RAM_DATA_WIDTH = 32,
  parameter int                     RAM_ADDR_WIDTH = 4,
  parameter int                     BYTE_WIDTH     = 8,
  parameter logic [RD_MODE_W-1:0]   RD_MODE        = RD_READ_FIRST,
  parameter int                     INIT_CLEAR     = 1,
  localparam int                    NB             = calc_nb(RAM_DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_en,
  input  logic                      a_wr,
  input  logic [NB-1:0]             a_be,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_DATA_WIDTH-1:0] a_din,
  output logic [RAM_DATA_WIDTH-1:0] a_dout,
  output logic                      a_valid,
  input  logic                      b_en,
  input  logic                      b_wr,
  input  logic [NB-1:0]             b_be,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_DATA_WIDTH-1:0] b_din,
  output logic [RAM_DATA_WIDTH-1:0] b_dout,
  output logic                      b_valid,
  output logic                      init_busy
);

  localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;
  localparam bit MODE_RF = (RD_MODE == RD_READ_FIRST);
  localparam bit MODE_WF = (RD_MODE == RD_WRITE_FIRST);
  localparam bit MODE_NC = (RD_MODE == RD_NO_CHANGE);

  generate
    if ((RAM_DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $fatal(1, "bram_sync_dp: RAM_DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (!(MODE_RF || MODE_WF || MODE_NC)) begin : g_bad_mode
      $fatal(1, "bram_sync_dp: unknown RD_MODE");
    end
  endgenerate

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

  logic                      clr_we;
  logic [RAM_ADDR_WIDTH-1:0] clr_addr;

  bram_init_ctrl #(
    .ADDR_W    (RAM_ADDR_WIDTH),
    .INIT_CLEAR(INIT_CLEAR != 0)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic a_acc, b_acc;
  assign a_acc = a_en && !init_busy && !rst;
  assign b_acc = b_en && !init_busy && !rst;

  // Clear writes borrow the port A write path; they never coincide with an accepted A access.
  logic                      a_we_m;
  logic [RAM_ADDR_WIDTH-1:0] a_waddr_m;
  logic [RAM_DATA_WIDTH-1:0] a_wdata_m;
  logic [NB-1:0]             a_wbe_m;
  logic                      b_we;

  assign a_we_m    = clr_we || (a_acc && a_wr);
  assign a_waddr_m = clr_we ? clr_addr : a_addr;
  assign a_wdata_m = clr_we ? '0 : a_din;
  assign a_wbe_m   = clr_we ? {NB{1'b1}} : a_be;
  assign b_we      = b_acc && b_wr;

  // B lanes are assigned first so overlapping A lanes override them on a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_we && b_be[i])
        mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (a_we_m && a_wbe_m[i])
        mem[a_waddr_m][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata_m[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  logic [RAM_DATA_WIDTH-1:0] a_old, b_old, a_merged, b_merged;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_merge
      assign a_merged[g*BYTE_WIDTH +: BYTE_WIDTH] =
        a_be[g] ? a_din[g*BYTE_WIDTH +: BYTE_WIDTH] : a_old[g*BYTE_WIDTH +: BYTE_WIDTH];
      assign b_merged[g*BYTE_WIDTH +: BYTE_WIDTH] =
        b_be[g] ? b_din[g*BYTE_WIDTH +: BYTE_WIDTH] : b_old[g*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  logic [RAM_DATA_WIDTH-1:0] a_q, b_q;
  logic                      a_vq, b_vq;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      a_vq <= 1'b0;
    end else begin
      a_vq <= 1'b0;
      if (a_acc) begin
        if (!a_wr || MODE_RF) begin
          a_q  <= a_old;
          a_vq <= 1'b1;
        end else if (MODE_WF) begin
          a_q  <= a_merged;
          a_vq <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q  <= '0;
      b_vq <= 1'b0;
    end else begin
      b_vq <= 1'b0;
      if (b_acc) begin
        if (!b_wr || MODE_RF) begin
          b_q  <= b_old;
          b_vq <= 1'b1;
        end else if (MODE_WF) begin
          b_q  <= b_merged;
          b_vq <= 1'b1;
        end
      end
    end
  end

`ifdef BRAM_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout  <= '0;
      a_valid <= 1'b0;
      b_dout  <= '0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= a_vq;
      b_valid <= b_vq;
      if (a_vq) a_dout <= a_q;
      if (b_vq) b_dout <= b_q;
    end
  end
`else
  assign a_dout  = a_q;
  assign a_valid = a_vq;
  assign b_dout  = b_q;
  assign b_valid = b_vq;
`endif

endmodule

// File: tb/tb_bram_sync_dp.sv
// Directed bench for bram_sync_dp: one instance per read-during-write mode
// sharing the same stimulus; expected values are hand-computed constants.
module tb_bram_sync_dp;
  import bram_pkg::*;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_wr, b_en, b_wr;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] a_dout, b_dout, wf_a_dout, wf_b_dout, nc_a_dout, nc_b_dout;
  logic        a_valid, b_valid, wf_a_valid, wf_b_valid, nc_a_valid, nc_b_valid;
  logic        init_busy, wf_busy, nc_busy;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  bram_sync_dp u_dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_valid(b_valid),
    .init_busy(init_busy)
  );

  bram_sync_dp #(.RD_MODE(RD_WRITE_FIRST)) u_wf (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(wf_a_dout), .a_valid(wf_a_valid),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(wf_b_dout), .b_valid(wf_b_valid),
    .init_busy(wf_busy)
  );

  bram_sync_dp #(.RD_MODE(RD_NO_CHANGE)) u_nc (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(nc_a_dout), .a_valid(nc_a_valid),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(nc_b_dout), .b_valid(nc_b_valid),
    .init_busy(nc_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_req(input logic wr, input logic [3:0] addr, input logic [31:0] din,
                       input logic [3:0] be);
    a_en = 1'b1; a_wr = wr; a_addr = addr; a_din = din; a_be = be;
    step;
    a_en = 1'b0; a_wr = 1'b0;
    repeat (LAT - 1) step;
  endtask

  task automatic b_req(input logic wr, input logic [3:0] addr, input logic [31:0] din,
                       input logic [3:0] be);
    b_en = 1'b1; b_wr = wr; b_addr = addr; b_din = din; b_be = be;
    step;
    b_en = 1'b0; b_wr = 1'b0;
    repeat (LAT - 1) step;
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_wr = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_din = 32'h0;
    b_en = 1'b0; b_wr = 1'b0; b_be = 4'h0; b_addr = 4'h0; b_din = 32'h0;
    step; step;

    chk("rst_busy",    init_busy, 32'd1);
    chk("rst_a_dout",  a_dout,    32'h0);
    chk("rst_a_valid", a_valid,   32'd0);
    chk("rst_b_dout",  b_dout,    32'h0);
    chk("rst_b_valid", b_valid,   32'd0);

    // Keep a B write pending across the whole clear; it must be dropped.
    rst = 1'b0;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd2; b_din = 32'hFFFF_FFFF; b_be = 4'hF;
    n = 0;
    while (init_busy && n < 100) begin
      step;
      n++;
    end
    b_en = 1'b0; b_wr = 1'b0;
    chk("clear_cycles", n, 32'd16);
    chk("busy_b_valid", b_valid, 32'd0);

    for (int i = 0; i < 16; i++) begin
      a_req(1'b0, i[3:0], 32'h0, 4'h0);
      chk($sformatf("clr_rd%0d", i), a_dout, 32'h0);
      chk($sformatf("clr_v%0d", i), a_valid, 32'd1);
    end
    step;
    chk("valid_drops", a_valid, 32'd0);

    a_req(1'b1, 4'd3, 32'h1122_3344, 4'hF);
    a_req(1'b1, 4'd3, 32'hDEAD_BEEF, 4'h5);
    chk("rf_old_word", a_dout, 32'h1122_3344);
    b_req(1'b0, 4'd3, 32'h0, 4'h0);
    chk("be_merge_b", b_dout, 32'h11AD_33EF);
    chk("be_merge_bv", b_valid, 32'd1);

    a_req(1'b1, 4'd5, 32'h1234_5678, 4'hF);
    a_req(1'b0, 4'd5, 32'h0, 4'h0);
    chk("nc_rd5", nc_a_dout, 32'h1234_5678);
    a_req(1'b0, 4'd0, 32'h0, 4'h0);
    chk("nc_rd0", nc_a_dout, 32'h0);
    a_req(1'b1, 4'd5, 32'hCAFE_F00D, 4'hF);
    chk("rf_dout",  a_dout,     32'h1234_5678);
    chk("rf_valid", a_valid,    32'd1);
    chk("wf_dout",  wf_a_dout,  32'hCAFE_F00D);
    chk("wf_valid", wf_a_valid, 32'd1);
    chk("nc_dout",  nc_a_dout,  32'h0);
    chk("nc_valid", nc_a_valid, 32'd0);
    step; step;
    chk("en0_hold",  a_dout,  32'h1234_5678);
    chk("en0_valid", a_valid, 32'd0);

    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd7; a_din = 32'hAAAA_AAAA; a_be = 4'h3;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd7; b_din = 32'hBBBB_BBBB; b_be = 4'hF;
    step;
    a_en = 1'b0; b_en = 1'b0; a_wr = 1'b0; b_wr = 1'b0;
    repeat (LAT - 1) step;
    // Read latency on the merged collision word.
    a_en = 1'b1; a_addr = 4'd7;
    step;
    a_en = 1'b0;
    chk("lat_first_edge", a_valid, (LAT == 1) ? 32'd1 : 32'd0);
    repeat (LAT - 1) step;
    chk("collide_ww", a_dout, 32'hBBBB_AAAA);
    chk("lat_valid",  a_valid, 32'd1);

    a_req(1'b1, 4'd9, 32'h0000_0001, 4'hF);
    a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd9;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd9; b_din = 32'h0000_0002; b_be = 4'hF;
    step;
    a_en = 1'b0; b_en = 1'b0; b_wr = 1'b0;
    repeat (LAT - 1) step;
    chk("collide_rw_a", a_dout,     32'h0000_0001);
    chk("collide_rw_b", b_dout,     32'h0000_0001);
    chk("collide_wf_b", wf_b_dout,  32'h0000_0002);
    chk("collide_nc_b", nc_b_valid, 32'd0);
    a_req(1'b0, 4'd9, 32'h0, 4'h0);
    chk("after_rw_a", a_dout, 32'h0000_0002);

    a_req(1'b1, 4'd12, 32'h5A5A_5A5A, 4'hF);
    rst = 1'b1;
    step;
    rst = 1'b0;
    repeat (8) step;
    chk("mid_busy", init_busy, 32'd1);
    rst = 1'b1;
    step;
    chk("mid_rst_dout", a_dout, 32'h0);
    chk("mid_rst_busy", init_busy, 32'd1);
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 100) begin
      step;
      n++;
    end
    chk("restart_cycles", n, 32'd16);
    a_req(1'b0, 4'd12, 32'h0, 4'h0);
    chk("reclr_12", a_dout, 32'h0);
    a_req(1'b0, 4'd3, 32'h0, 4'h0);
    chk("reclr_3", a_dout, 32'h0);
    b_req(1'b0, 4'd9, 32'h0, 4'h0);
    chk("reclr_9", b_dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
